// File: rtl/decimating_averager.sv
// decimating_averager
//   Consumes a signed sample stream and emits one output per window of 2^k
//   accepted samples. Each output carries the rounded window mean together
//   with the window maximum and minimum.
//
// Ports
//   clk             sole clock, rising edge
//   resetn          asynchronous active-low reset (release synchronised)
//   decimationLog2  k, window length 2^k, clamped to MAX_LOG2_DECIMATION
//   restart         one-cycle pulse, discards the partial window
//   S_TVALID/TDATA  input sample strobe and signed sample (no backpressure)
//   M_TVALID        one-cycle pulse per completed window
//   M_TDATA         signed rounded mean (half rounds toward +inf)
//   M_TMAX/M_TMIN   signed window maximum / minimum
module decimating_averager #(
    parameter int TDATA_WIDTH         = 24,
    parameter int MAX_LOG2_DECIMATION = 8
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  logic [$clog2(MAX_LOG2_DECIMATION+1)-1:0]   decimationLog2,
    input  logic                                       restart,
    input  logic                                       S_TVALID,
    input  logic [TDATA_WIDTH-1:0]                     S_TDATA,
    output logic                                       M_TVALID,
    output logic [TDATA_WIDTH-1:0]                     M_TDATA,
    output logic [TDATA_WIDTH-1:0]                     M_TMAX,
    output logic [TDATA_WIDTH-1:0]                     M_TMIN
);

    localparam int W  = TDATA_WIDTH;
    localparam int M  = MAX_LOG2_DECIMATION;
    localparam int AW = W + M;
    localparam int KW = $clog2(M + 1);
    localparam int CW = M + 1;

    logic                 run;
    logic [KW-1:0]        k_latched;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic signed [W-1:0]  max_q;
    logic signed [W-1:0]  min_q;

    logic                 accept;
    logic                 rst_win;
    logic                 first;
    logic                 done;
    logic [KW-1:0]        k_clamped;
    logic [KW-1:0]        k_eff;
    logic [CW-1:0]        cnt_inc;
    logic signed [W-1:0]  sample;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] acc_rnd;
    logic signed [W-1:0]  max_new;
    logic signed [W-1:0]  min_new;

    // Release is registered once, so the first edge after resetn rises is
    // idle and the first sample can be accepted on the second edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) run <= 1'b0;
        else         run <= 1'b1;
    end

    assign sample  = S_TDATA;
    assign accept  = S_TVALID & run;
    assign rst_win = restart & run;

    always_comb begin
        k_clamped = (decimationLog2 > KW'(M)) ? KW'(M) : decimationLog2;
        // A restart sample or an empty window opens a new window, which uses
        // the live decimationLog2 rather than the latched one.
        first     = rst_win || (cnt == '0);
        k_eff     = first ? k_clamped : k_latched;
        cnt_inc   = (first ? '0 : cnt) + CW'(1);
        acc_sum   = (first ? '0 : acc) + {{M{sample[W-1]}}, sample};
        max_new   = (first || (sample > max_q)) ? sample : max_q;
        min_new   = (first || (sample < min_q)) ? sample : min_q;
        done      = accept && (cnt_inc == (CW'(1) << k_eff));
        // Adding 2^(k-1) before the arithmetic shift rounds half toward +inf;
        // the sum cannot overflow AW bits for k <= M.
        rnd       = (k_eff == '0) ? '0 : (AW'(1) << (k_eff - KW'(1)));
        acc_rnd   = acc_sum + rnd;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k_latched <= '0;
            cnt       <= '0;
            acc       <= '0;
            max_q     <= '0;
            min_q     <= '0;
            M_TVALID  <= 1'b0;
            M_TDATA   <= '0;
            M_TMAX    <= '0;
            M_TMIN    <= '0;
        end else begin
            M_TVALID <= 1'b0;
            if (accept) begin
                if (first) k_latched <= k_clamped;
                max_q <= max_new;
                min_q <= min_new;
                if (done) begin
                    cnt      <= '0;
                    acc      <= '0;
                    M_TVALID <= 1'b1;
                    M_TDATA  <= W'(acc_rnd >>> k_eff);
                    M_TMAX   <= max_new;
                    M_TMIN   <= min_new;
                end else begin
                    cnt <= cnt_inc;
                    acc <= acc_sum;
                end
            end else if (rst_win) begin
                cnt <= '0;
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decimating_averager.sv
// Bench for decimating_averager: table of fixed windows, hand-written
// boundary sequences, then randomized traffic against a queue-based model.
module tb_decimating_averager;

    localparam int W = 24;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   dec = 4'd0;
    logic         restart = 1'b0;
    logic         S_TVALID = 1'b0;
    logic [W-1:0] S_TDATA = '0;
    logic         M_TVALID;
    logic [W-1:0] M_TDATA;
    logic [W-1:0] M_TMAX;
    logic [W-1:0] M_TMIN;

    decimating_averager #(.TDATA_WIDTH(W), .MAX_LOG2_DECIMATION(M)) dut (
        .clk(clk), .resetn(resetn), .decimationLog2(dec), .restart(restart),
        .S_TVALID(S_TVALID), .S_TDATA(S_TDATA), .M_TVALID(M_TVALID),
        .M_TDATA(M_TDATA), .M_TMAX(M_TMAX), .M_TMIN(M_TMIN)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     pulses = 0;
    int     edges  = 0;
    longint win[$];
    int     wk = 0;
    longint h_mean = 0, h_max = 0, h_min = 0;
    bit     exp_v = 1'b0;

    typedef struct {
        int k; int n; int base; int inc; int mean; int mx; int mn;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint p);
        longint q;
        q = n / p;
        if ((n % p) != 0 && n < 0) q--;
        return q;
    endfunction

    function automatic longint sx(input logic [W-1:0] x);
        return longint'($signed(x));
    endfunction

    // Model predicts the result of this cycle, then the DUT is clocked and
    // every output is compared one time unit after the edge.
    task automatic step(input bit v, input int d, input bit rs);
        longint s, mx, mn;
        exp_v = 1'b0;
        if (edges >= 1) begin
            if (rs) win.delete();
            if (v) begin
                if (win.size() == 0) wk = (int'(dec) > M) ? M : int'(dec);
                win.push_back(longint'(d));
                if (win.size() == (1 << wk)) begin
                    s = 0; mx = win[0]; mn = win[0];
                    foreach (win[i]) begin
                        s += win[i];
                        if (win[i] > mx) mx = win[i];
                        if (win[i] < mn) mn = win[i];
                    end
                    if (wk > 0) s += longint'(1) << (wk - 1);
                    h_mean = floor_div(s, longint'(1) << wk);
                    h_max  = mx;
                    h_min  = mn;
                    exp_v  = 1'b1;
                    win.delete();
                end
            end
        end
        S_TVALID = v; S_TDATA = W'(d); restart = rs;
        @(posedge clk);
        edges++;
        #1;
        if (M_TVALID) pulses++;
        chk("tvalid", longint'(M_TVALID), longint'(exp_v));
        chk("mean", sx(M_TDATA), h_mean);
        chk("max", sx(M_TMAX), h_max);
        chk("min", sx(M_TMIN), h_min);
        S_TVALID = 1'b0; restart = 1'b0; S_TDATA = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_tvalid", longint'(M_TVALID), 0);
        chk("rst_mean", sx(M_TDATA), 0);
        chk("rst_max", sx(M_TMAX), 0);
        chk("rst_min", sx(M_TMIN), 0);
        win.delete();
        h_mean = 0; h_max = 0; h_min = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        edges = 0;
    endtask

    initial begin
        int p0;
        int d;

        vt[0] = '{4, 16, 8388607, 0, 8388607, 8388607, 8388607};
        vt[1] = '{4, 16, -8388608, 0, -8388608, -8388608, -8388608};
        vt[2] = '{4, 16, 0, 1, 8, 15, 0};
        vt[3] = '{1, 2, 1, 1, 2, 2, 1};
        vt[4] = '{1, 2, -1, -1, -1, -1, -2};
        vt[5] = '{1, 2, -1, 0, -1, -1, -1};

        #3;
        do_reset();
        // First edge after release must not accept a sample.
        step(1, 77, 0);
        chk("first_edge_ignored", longint'(win.size()), 0);
        step(0, 0, 0);

        // Table-driven windows, with idle gaps between some samples.
        foreach (vt[v]) begin
            dec = 4'(vt[v].k);
            p0 = pulses;
            for (int i = 0; i < vt[v].n; i++) begin
                if (i % 5 == 2) step(0, 0, 0);
                step(1, vt[v].base + i * vt[v].inc, 0);
            end
            chk("vec_pulses", pulses - p0, 1);
            chk("vec_mean", sx(M_TDATA), vt[v].mean);
            chk("vec_max", sx(M_TMAX), vt[v].mx);
            chk("vec_min", sx(M_TMIN), vt[v].mn);
            step(0, 0, 0);
        end

        // k=0 back-to-back: one output per sample, one cycle later.
        dec = 4'd0;
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            step(1, (i % 2) ? -1000000 : 1000000, 0);
            chk("k0_mean", sx(M_TDATA), (i % 2) ? -1000000 : 1000000);
        end
        chk("k0_pulses", pulses - p0, 10);

        // Restart with a sample discards the partial window.
        dec = 4'd2;
        p0 = pulses;
        repeat (3) step(1, 5, 0);
        step(1, 100, 1);
        repeat (3) step(1, 100, 0);
        chk("restart_pulses", pulses - p0, 1);
        chk("restart_mean", sx(M_TDATA), 100);

        // Restart on what would have been the final sample: restart wins.
        p0 = pulses;
        repeat (3) step(1, 9, 0);
        step(1, 50, 1);
        chk("restart_final_none", pulses - p0, 0);
        repeat (3) step(1, 50, 0);
        chk("restart_final_pulses", pulses - p0, 1);
        chk("restart_final_mean", sx(M_TDATA), 50);

        // Mid-window change of k takes effect only at the next window.
        dec = 4'd2;
        p0 = pulses;
        step(1, 1, 0);
        dec = 4'd3;
        repeat (3) step(1, 2, 0);
        chk("kchg_first", pulses - p0, 1);
        chk("kchg_mean1", sx(M_TDATA), 2);
        repeat (7) step(1, 3, 0);
        chk("kchg_wait", pulses - p0, 1);
        step(1, 3, 0);
        chk("kchg_second", pulses - p0, 2);

        // Reset mid-window, then a clean 4-sample window.
        dec = 4'd2;
        step(1, 7, 0);
        step(1, 8, 0);
        do_reset();
        step(0, 0, 0);
        p0 = pulses;
        for (int i = 0; i < 4; i++) step(1, 7 + i, 0);
        chk("post_rst_pulses", pulses - p0, 1);
        chk("post_rst_mean", sx(M_TDATA), 9);
        chk("post_rst_max", sx(M_TMAX), 10);
        chk("post_rst_min", sx(M_TMIN), 7);
        // Reset while the pulse is high drops it immediately.
        do_reset();
        step(0, 0, 0);

        // Randomized traffic, including clamped k and full-scale samples.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3)
                dec = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15))
                                                   : 4'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: d = 8388607;
                1: d = -8388608;
                default: d = int'($signed(24'($urandom)));
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
